// File: rtl/boss_pkg.sv
// Shared boss/bomb definitions: screen geometry, kid size, the bomb slot record and launcher states.
package boss_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int KID_SIZE = 32;

    typedef struct packed {
        logic       active;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] vx;
        logic [9:0] vy;
    } bomb_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_FLY
    } launch_state_t;

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: spawns at the boss centre, moves once per frame, retires off-screen or on kid
// contact, and reports whether the current VGA pixel falls inside its 16x16 sprite.
module bomb_slot
    import boss_pkg::*;
#(
    parameter int INDEX      = 0,
    parameter int N_BOMBS    = 4,
    parameter int BOMB_SPEED = 4,
    parameter int BOMB_HALF  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        spawn,
    input  logic [9:0]  boss_x,
    input  logic [9:0]  boss_y,
    input  logic [9:0]  kid_x,
    input  logic [9:0]  kid_y,
    input  logic [9:0]  draw_x,
    input  logic [9:0]  draw_y,
    output logic        alive_next,
    output logic        touch,
    output logic        in_pixel,
    output logic [24:0] offset
);

    bomb_t      bomb;
    bomb_t      bomb_next;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       off_screen;
    logic       overlap;
    int         dx;
    int         dy;

    always_comb begin
        nx = bomb.x + bomb.vx;
        ny = bomb.y + bomb.vy;
        // A move past 0 wraps to a large value, so one upper-bound test catches both edges.
        off_screen = (int'(nx) >= SCREEN_W) || (int'(ny) >= SCREEN_H);
        overlap = (int'(nx) - BOMB_HALF <= int'(kid_x) + KID_SIZE - 1) &&
                  (int'(nx) + BOMB_HALF - 1 >= int'(kid_x)) &&
                  (int'(ny) - BOMB_HALF <= int'(kid_y) + KID_SIZE - 1) &&
                  (int'(ny) + BOMB_HALF - 1 >= int'(kid_y));
        touch = bomb.active && !off_screen && overlap;
        bomb_next = bomb;
        if (spawn) begin
            bomb_next.active = 1'b1;
            bomb_next.x      = boss_x;
            bomb_next.y      = boss_y;
            bomb_next.vx     = (int'(kid_x) + KID_SIZE / 2 >= int'(boss_x)) ?
                               10'(BOMB_SPEED) : 10'(-BOMB_SPEED);
            bomb_next.vy     = 10'(INDEX - N_BOMBS / 2);
        end else if (bomb.active) begin
            if (off_screen || touch) begin
                bomb_next = '0;
            end else begin
                bomb_next.x = nx;
                bomb_next.y = ny;
            end
        end
        alive_next = bomb_next.active;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            bomb <= '0;
        end else begin
            bomb <= bomb_next;
        end
    end

    // Sprite pixel (0,0) sits at (x-HALF, y-HALF); the sprite spans 2*HALF pixels each way.
    always_comb begin
        dx       = int'(draw_x) - int'(bomb.x) + BOMB_HALF;
        dy       = int'(draw_y) - int'(bomb.y) + BOMB_HALF;
        in_pixel = bomb.active && (dx >= 0) && (dx < 2 * BOMB_HALF) &&
                   (dy >= 0) && (dy < 2 * BOMB_HALF);
        offset   = in_pixel ? 25'(dx + 2 * BOMB_HALF * dy) : '0;
    end

endmodule

// File: rtl/boss_bomb_launcher.sv
// Boss bomb launcher: turns a one-frame shoot pulse into a timed fan of bombs aimed at the kid,
// and drives the per-pixel bomb sprite lookup, the kid hit pulse and the idle flag back to the boss.
module boss_bomb_launcher
    import boss_pkg::*;
#(
    parameter int          N_BOMBS     = 4,
    parameter int          SPAWN_GAP   = 8,
    parameter int          BOMB_SPEED  = 4,
    parameter int          BOMB_HALF   = 8,
    parameter logic [24:0] SPRITE_BASE = 25'd0
) (
    input  logic        frame_clk,
    input  logic        Reset_h,
    input  logic        shoot,
    input  logic        Boss_dead,
    input  logic [9:0]  Boss_position_X,
    input  logic [9:0]  Boss_position_Y,
    input  logic [9:0]  Kid_position_X,
    input  logic [9:0]  Kid_position_Y,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        NoBomb,
    output logic        isBomb,
    output logic [24:0] Bomb_address,
    output logic        hitKid
);

    localparam int CNT_W = $clog2((N_BOMBS - 1) * SPAWN_GAP + 2);

    launch_state_t      state;
    launch_state_t      state_next;
    logic [CNT_W-1:0]   spawn_cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [N_BOMBS-1:0] spawn;
    logic [N_BOMBS-1:0] alive_next;
    logic [N_BOMBS-1:0] touch;
    logic [N_BOMBS-1:0] in_pixel;
    logic [24:0]        offset [N_BOMBS];

    for (genvar g = 0; g < N_BOMBS; g++) begin : g_slot
        bomb_slot #(
            .INDEX      (g),
            .N_BOMBS    (N_BOMBS),
            .BOMB_SPEED (BOMB_SPEED),
            .BOMB_HALF  (BOMB_HALF)
        ) u_slot (
            .clk        (frame_clk),
            .reset      (Reset_h),
            .clear      (Boss_dead),
            .spawn      (spawn[g]),
            .boss_x     (Boss_position_X),
            .boss_y     (Boss_position_Y),
            .kid_x      (Kid_position_X),
            .kid_y      (Kid_position_Y),
            .draw_x     (DrawX),
            .draw_y     (DrawY),
            .alive_next (alive_next[g]),
            .touch      (touch[g]),
            .in_pixel   (in_pixel[g]),
            .offset     (offset[g])
        );
    end

    always_comb begin
        state_next = state;
        cnt_next   = spawn_cnt;
        spawn      = '0;
        unique case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (shoot) begin
                    state_next = ST_LAUNCH;
                    spawn[0]   = 1'b1;
                    cnt_next   = CNT_W'(1);
                end
            end
            ST_LAUNCH: begin
                // spawn_cnt counts frames since the volley started; slot k fires at k*SPAWN_GAP.
                cnt_next = spawn_cnt + CNT_W'(1);
                for (int k = 1; k < N_BOMBS; k++) begin
                    if (spawn_cnt == CNT_W'(k * SPAWN_GAP)) begin
                        spawn[k] = 1'b1;
                    end
                end
                if (spawn[N_BOMBS-1]) begin
                    state_next = ST_FLY;
                end
            end
            ST_FLY: begin
                if (alive_next == '0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (Boss_dead) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            spawn      = '0;
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset_h) begin
            state     <= ST_IDLE;
            spawn_cnt <= '0;
            NoBomb    <= 1'b1;
            hitKid    <= 1'b0;
        end else begin
            state     <= state_next;
            spawn_cnt <= cnt_next;
            NoBomb    <= (state_next == ST_IDLE);
            hitKid    <= (|touch) && !Boss_dead;
        end
    end

    // Walk from the top slot down so the lowest index overwrites and wins on overlap.
    always_comb begin
        isBomb       = 1'b0;
        Bomb_address = '0;
        for (int i = N_BOMBS - 1; i >= 0; i--) begin
            if (in_pixel[i]) begin
                isBomb       = 1'b1;
                Bomb_address = SPRITE_BASE + offset[i];
            end
        end
    end

endmodule
